// File: rtl/ev22_decode_pkg.sv
// Shared definitions for the EV22 decode stage.
// Holds the opcode group patterns, ALU codes, instruction-class constants,
// the default W-register selector and the packed control word that the
// decode table produces and the stage registers.
package ev22_decode_pkg;

    // Opcodes are decoded on opcode[7:2]; the low two bits are don't-care
    // for every class except W=K, which needs them to be 2'b00.
    localparam logic [5:0] OPG_WK  = 6'b0000_01;
    localparam logic [5:0] OPG_WRI = 6'b0000_10;
    localparam logic [5:0] OPG_RIW = 6'b0000_11;
    localparam logic [5:0] OPG_LD  = 6'b0001_00;
    localparam logic [5:0] OPG_ST  = 6'b0001_01;

    localparam logic [3:0] ALUC_NONE = 4'b0000;
    localparam logic [3:0] ALUC_PASS = 4'b0001;

    localparam logic [6:0] OPT_WK  = 7'b0000010;
    localparam logic [6:0] OPT_WRI = 7'b0000100;
    localparam logic [6:0] OPT_RIW = 7'b0001001;
    localparam logic [6:0] OPT_LD  = 7'b0010000;
    localparam logic [6:0] OPT_ST  = 7'b0100000;

    localparam int W_SEL_DEF = 34;

    // Selector fields are carried at a fixed maximum width so the struct
    // can live in the package; the stage trims them to SEL_W at its ports.
    localparam int SEL_MAX_W = 16;

    typedef struct packed {
        logic [3:0]           aluc;
        logic [1:0]           sh;
        logic                 kmux;
        logic                 mr;
        logic                 mw;
        logic [SEL_MAX_W-1:0] sel_b;
        logic [SEL_MAX_W-1:0] sel_c;
        logic [6:0]           op_type;
        logic                 illegal;
    } ctl_word_t;

endpackage

// File: rtl/ev22_decode_lut.sv
// Purely combinational decode table: opcode + Ri -> control word.
// Ports:
//   opcode   in   8      instruction opcode
//   ri       in   RI_W   register index
//   word     out         decoded control word (all zero + illegal for unknown)
//   reads_w  out  1      instruction consumes the W register
//   is_load  out  1      instruction is a memory load into W
module ev22_decode_lut
    import ev22_decode_pkg::*;
#(
    parameter int RI_W  = 5,
    parameter int W_SEL = W_SEL_DEF
) (
    input  logic [7:0]      opcode,
    input  logic [RI_W-1:0] ri,
    output ctl_word_t       word,
    output logic            reads_w,
    output logic            is_load
);

    logic [SEL_MAX_W-1:0] ri_sel;
    logic [SEL_MAX_W-1:0] w_sel;

    assign ri_sel = SEL_MAX_W'(ri);
    assign w_sel  = SEL_MAX_W'(W_SEL);

    always_comb begin
        word    = '0;
        reads_w = 1'b0;
        is_load = 1'b0;
        case (opcode[7:2])
            OPG_WK: begin
                if (opcode[1:0] == 2'b00) begin
                    word.kmux    = 1'b1;
                    word.sel_c   = w_sel;
                    word.op_type = OPT_WK;
                end else begin
                    word.illegal = 1'b1;
                end
            end
            OPG_RIW: begin
                word.aluc    = ALUC_PASS;
                word.sel_b   = w_sel;
                word.sel_c   = ri_sel;
                word.op_type = OPT_RIW;
                reads_w      = 1'b1;
            end
            OPG_WRI: begin
                word.aluc    = ALUC_PASS;
                word.sel_b   = ri_sel;
                word.sel_c   = w_sel;
                word.op_type = OPT_WRI;
            end
            OPG_LD: begin
                word.mr      = 1'b1;
                word.sel_b   = ri_sel;
                word.sel_c   = w_sel;
                word.op_type = OPT_LD;
                is_load      = 1'b1;
            end
            OPG_ST: begin
                word.mw      = 1'b1;
                word.sel_b   = w_sel;
                word.op_type = OPT_ST;
                reads_w      = 1'b1;
            end
            default: word.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ev22_decode_stage.sv
// EV22 instruction-decode stage between fetch and execute.
// Decodes opcode/Ri into a registered control word with valid/ready flow
// control, and holds back W-register readers while a load is in flight.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid / in_ready      fetch-side handshake
//   opcode, ri               instruction fields
//   flush                    synchronous flush (drops word, clears hazard)
//   out_valid / out_ready    execute-side handshake
//   aluc, sh, kmux, mr, mw,
//   sel_b, sel_c, op_type    registered control word
//   illegal                  registered word is an undefined opcode
module ev22_decode_stage
    import ev22_decode_pkg::*;
#(
    parameter int RI_W     = 5,
    parameter int SEL_W    = 6,
    parameter int W_SEL    = W_SEL_DEF,
    parameter int LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [RI_W-1:0]  ri,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       aluc,
    output logic [1:0]       sh,
    output logic             kmux,
    output logic             mr,
    output logic             mw,
    output logic [SEL_W-1:0] sel_b,
    output logic [SEL_W-1:0] sel_c,
    output logic [6:0]       op_type,
    output logic             illegal
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    if (SEL_W < RI_W + 1 || SEL_W > SEL_MAX_W || LOAD_LAT < 1) begin : g_bad_params
        $error("ev22_decode_stage: illegal parameter combination");
    end

    ctl_word_t        dec_word;
    ctl_word_t        word_q;
    logic             dec_reads_w;
    logic             dec_is_load;
    logic [CNT_W-1:0] ld_cnt;
    logic             stall;
    logic             accept;

    ev22_decode_lut #(
        .RI_W  (RI_W),
        .W_SEL (W_SEL)
    ) u_lut (
        .opcode  (opcode),
        .ri      (ri),
        .word    (dec_word),
        .reads_w (dec_reads_w),
        .is_load (dec_is_load)
    );

    // The hazard check uses the registered counter, so a reader offered in
    // the cycle right after a load is already blocked.
    assign stall    = in_valid && dec_reads_w && (ld_cnt != '0);
    assign in_ready = !flush && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            word_q    <= '0;
            ld_cnt    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ld_cnt    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                word_q    <= dec_word;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && dec_is_load) begin
                ld_cnt <= CNT_W'(LOAD_LAT);
            end else if (ld_cnt != '0) begin
                ld_cnt <= ld_cnt - CNT_W'(1);
            end
        end
    end

    assign aluc    = word_q.aluc;
    assign sh      = word_q.sh;
    assign kmux    = word_q.kmux;
    assign mr      = word_q.mr;
    assign mw      = word_q.mw;
    assign sel_b   = word_q.sel_b[SEL_W-1:0];
    assign sel_c   = word_q.sel_c[SEL_W-1:0];
    assign op_type = word_q.op_type;
    assign illegal = word_q.illegal;

    // Upper selector bits are always zero for legal parameter sets.
    logic unused_sel;
    assign unused_sel = &{1'b0, word_q.sel_b, word_q.sel_c};

endmodule

// File: tb/tb_ev22_decode_stage.sv
module tb_ev22_decode_stage;

    localparam int RI_W     = 5;
    localparam int SEL_W    = 6;
    localparam int W_SEL    = 34;
    localparam int LOAD_LAT = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       opcode;
    logic [RI_W-1:0]  ri;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       aluc;
    logic [1:0]       sh;
    logic             kmux;
    logic             mr;
    logic             mw;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] sel_c;
    logic [6:0]       op_type;
    logic             illegal;

    ev22_decode_stage #(
        .RI_W     (RI_W),
        .SEL_W    (SEL_W),
        .W_SEL    (W_SEL),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .ri        (ri),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluc      (aluc),
        .sh        (sh),
        .kmux      (kmux),
        .mr        (mr),
        .mw        (mw),
        .sel_b     (sel_b),
        .sel_c     (sel_c),
        .op_type   (op_type),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: instruction semantics from the decode rules.
    typedef struct {
        int aluc;
        int kmux;
        int mr;
        int mw;
        int sel_b;
        int sel_c;
        int op_type;
        int illegal;
        bit reads_w;
        bit is_load;
    } ref_t;

    function automatic ref_t ref_decode(input int op, input int r);
        ref_t d = '{default: 0};
        int grp = op / 4;
        if (op == 4) begin
            d.kmux = 1; d.sel_c = W_SEL; d.op_type = 2;
        end else if (grp == 3) begin
            d.aluc = 1; d.sel_b = W_SEL; d.sel_c = r; d.op_type = 9; d.reads_w = 1;
        end else if (grp == 2) begin
            d.aluc = 1; d.sel_b = r; d.sel_c = W_SEL; d.op_type = 4;
        end else if (grp == 4) begin
            d.mr = 1; d.sel_b = r; d.sel_c = W_SEL; d.op_type = 16; d.is_load = 1;
        end else if (grp == 5) begin
            d.mw = 1; d.sel_b = W_SEL; d.op_type = 32; d.reads_w = 1;
        end else begin
            d.illegal = 1;
        end
        return d;
    endfunction

    bit   m_valid;
    ref_t m_word;
    int   m_cyc;
    int   m_last_load;
    int   n_cons;

    task automatic model_reset();
        m_valid     = 1'b0;
        m_word      = '{default: 0};
        m_last_load = -1000;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, out_valid, m_valid);
        if (m_valid) begin
            check({tag, ".aluc"},    aluc,    m_word.aluc);
            check({tag, ".sh"},      sh,      0);
            check({tag, ".kmux"},    kmux,    m_word.kmux);
            check({tag, ".mr"},      mr,      m_word.mr);
            check({tag, ".mw"},      mw,      m_word.mw);
            check({tag, ".sel_b"},   sel_b,   m_word.sel_b);
            check({tag, ".sel_c"},   sel_c,   m_word.sel_c);
            check({tag, ".op_type"}, op_type, m_word.op_type);
            check({tag, ".illegal"}, illegal, m_word.illegal);
        end
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    // obs_acc reports whether the DUT itself took the instruction.
    task automatic step(input string tag, input bit v, input logic [7:0] op,
                        input logic [RI_W-1:0] r, input bit rdy, input bit fl,
                        output bit obs_acc);
        ref_t d;
        bit   exp_rdy;
        bit   w_busy;
        in_valid  = v;
        opcode    = op;
        ri        = r;
        out_ready = rdy;
        flush     = fl;
        #3;
        d       = ref_decode(int'(op), int'(r));
        w_busy  = (m_cyc - m_last_load) <= LOAD_LAT;
        exp_rdy = !fl && !(v && d.reads_w && w_busy) && (!m_valid || rdy);
        check({tag, ".in_ready"}, in_ready, exp_rdy);
        check_outputs(tag);
        obs_acc = v && in_ready;
        if (out_valid && rdy) n_cons++;
        @(posedge clk);
        if (fl) begin
            m_valid     = 1'b0;
            m_last_load = -1000;
        end else if (v && exp_rdy) begin
            m_valid = 1'b1;
            m_word  = d;
            if (d.is_load) m_last_load = m_cyc;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        m_cyc++;
        #1;
    endtask

    logic [7:0] ops_tab [8] = '{8'h04, 8'h0C, 8'h0E, 8'h08, 8'h0B, 8'h10, 8'h13, 8'h14};
    bit         pat [3]     = '{1'b1, 1'b0, 1'b1};

    initial begin
        bit         got;
        int         budget;
        int         stalls;
        int         p;
        logic [7:0] op;

        m_cyc     = 0;
        n_cons    = 0;
        model_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        opcode    = 8'h00;
        ri        = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready",  in_ready,  1);
        check("rst.sel_c",     sel_c,     0);
        check("rst.op_type",   op_type,   0);
        check("rst.illegal",   illegal,   0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // W=K
        step("wk", 1'b1, 8'h04, '0, 1'b1, 1'b0, got);
        check("wk.accepted", got, 1);
        check("wk.kmux_now",  kmux,    1);
        check("wk.sel_c_now", sel_c,   34);
        check("wk.optype_now", op_type, 7'b0000010);
        step("drain", 1'b0, 8'h00, '0, 1'b1, 1'b0, got);

        // Ri=W stream with out_ready toggling
        n_cons = 0;
        p      = 0;
        for (int k = 0; k < 4; k++) begin
            op     = 8'(12 + k);
            got    = 1'b0;
            budget = 0;
            while (!got && budget < 20) begin
                step("riw", 1'b1, op, 5'd3, pat[p % 3], 1'b0, got);
                p++;
                budget++;
            end
            check("riw.accept", got, 1);
        end
        budget = 0;
        while (out_valid && budget < 10) begin
            step("riw_drain", 1'b0, 8'h00, '0, 1'b1, 1'b0, got);
            budget++;
        end
        check("riw.consumed", n_cons, 4);

        // Load followed by a W reader
        step("ld", 1'b1, 8'h10, 5'd5, 1'b1, 1'b0, got);
        check("ld.accept", got, 1);
        stalls = 0;
        got    = 1'b0;
        while (!got && stalls < 10) begin
            step("ld_riw", 1'b1, 8'h0C, 5'd3, 1'b1, 1'b0, got);
            if (!got) stalls++;
        end
        check("ld.stall_cycles", stalls, LOAD_LAT);

        // Load followed by a non-W reader
        step("ld2", 1'b1, 8'h10, 5'd5, 1'b1, 1'b0, got);
        stalls = 0;
        got    = 1'b0;
        while (!got && stalls < 10) begin
            step("ld_wri", 1'b1, 8'h08, 5'd9, 1'b1, 1'b0, got);
            if (!got) stalls++;
        end
        check("ld.nostall", stalls, 0);

        // Illegal opcode
        step("ill", 1'b1, 8'hFF, 5'd7, 1'b1, 1'b0, got);
        check("ill.flag",  illegal, 1);
        check("ill.sel_b", sel_b,   0);
        check("ill.valid", out_valid, 1);
        step("drain", 1'b0, 8'h00, '0, 1'b1, 1'b0, got);
        step("drain", 1'b0, 8'h00, '0, 1'b1, 1'b0, got);
        step("drain", 1'b0, 8'h00, '0, 1'b1, 1'b0, got);

        // Flush with a held word and a load in flight
        step("fl_ld", 1'b1, 8'h10, 5'd1, 1'b0, 1'b0, got);
        check("fl.ld_accept", got, 1);
        step("fl", 1'b0, 8'h00, '0, 1'b0, 1'b1, got);
        check("fl.out_valid", out_valid, 0);
        step("fl_st", 1'b1, 8'h14, 5'd2, 1'b1, 1'b0, got);
        check("fl.store_accept", got, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit         v;
            bit         rdy;
            bit         fl;
            logic [7:0] rop;
            v   = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            fl  = ($urandom % 16) == 0;
            if (($urandom % 8) == 0) rop = 8'($urandom);
            else                     rop = ops_tab[$urandom % 8];
            step("rnd", v, rop, RI_W'($urandom), rdy, fl, got);
        end

        // Asynchronous reset mid-stream
        step("pre_rst", 1'b0, 8'h00, '0, 1'b1, 1'b0, got);
        step("pre_rst", 1'b1, 8'h08, 5'd7, 1'b0, 1'b0, got);
        check("arst.valid_before", out_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst.out_valid", out_valid, 0);
        check("arst.aluc",      aluc,      0);
        check("arst.sel_b",     sel_b,     0);
        check("arst.sel_c",     sel_c,     0);
        check("arst.op_type",   op_type,   0);
        model_reset();
        @(posedge clk);
        m_cyc++;
        #1 reset_n = 1'b1;
        step("post_rst", 1'b1, 8'h0C, 5'd4, 1'b1, 1'b0, got);
        check("post_rst.accept", got, 1);
        step("post_rst", 1'b0, 8'h00, '0, 1'b1, 1'b0, got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
